uart_rx: RTL and testbench

Serial receiver that turns the UART line into bytes for the SRAM command controller. Oversamples the line against a parameterised bit period, assembles 8N1 frames LSB-first, and holds each byte in a one-entry buffer presented on the `rx_data_out`/`rx_valid`/`rx_ready` handshake that the controller consumes. Sits between the chip's `uart_rxd` pad and the controller's rx port.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_if.sv | 12 +
 rtl/sync_2ff.sv | 20 ++
 rtl/uart_rx.sv | 183 ++++++++++++++++++
 tb/tb_uart_rx.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and default bit period.
package uart_pkg;

    localparam int unsigned UART_DATA_W       = 8;
    localparam int unsigned UART_CLKS_PER_BIT = 104;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Byte handshake between the UART receiver (master) and the command controller (slave).
interface uart_rx_if;
    import uart_pkg::*;

    logic                   rx_valid;
    logic                   rx_ready;
    logic [UART_DATA_W-1:0] rx_data_out;

    modport master (output rx_valid, output rx_data_out, input rx_ready);
    modport slave  (input rx_valid, input rx_data_out, output rx_ready);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit with a configurable reset value.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] ff_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ff_q <= {2{RST_VAL}};
        else        ff_q <= {ff_q[0], d_i};
    end

    assign q_o = ff_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling of 8N1 frames (8E1 with UART_RX_PARITY_EN) into a
// one-entry byte buffer on a valid/ready handshake.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     uart_rxd,
    input  logic     rx_enable,
    uart_rx_if.master rx_if,
    output logic     frame_err,
    output logic     overrun,
    output logic     parity_err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

    logic                   rxd_s;
    uart_state_e            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic [UART_DATA_W-1:0] data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ovr_q, ovr_d;
    logic                   expire_c, deliver_c, ferr_c;
`ifdef UART_RX_PARITY_EN
    logic                   par_bad_q, par_bad_d;
    logic                   perr_q, perr_c;
`endif

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (uart_rxd),
        .q_o  (rxd_s)
    );

    assign expire_c = (cnt_q == '0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; dropping rx_enable aborts any frame
    always_comb begin
        state_d = state_q;
        if (!rx_enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:      if (!rxd_s) state_d = START;
                START:     if (expire_c) state_d = rxd_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
                DATA:      if (expire_c && idx_q == 3'd7) state_d = PARITY;
                PARITY:    if (expire_c) state_d = STOP;
`else
                DATA:      if (expire_c && idx_q == 3'd7) state_d = STOP;
`endif
                STOP:      if (expire_c) state_d = rxd_s ? IDLE : WAIT_HIGH;
                WAIT_HIGH: if (rxd_s) state_d = IDLE;
                default:   state_d = IDLE;
            endcase
        end
    end

    // Datapath and output decode
    always_comb begin
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        deliver_c = 1'b0;
        ferr_c    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_c    = 1'b0;
`endif
        case (state_q)
            IDLE: if (!rxd_s) cnt_d = CNT_HALF;
            START: begin
                if (expire_c) begin
                    cnt_d = CNT_FULL;
                    idx_d = 3'd0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DATA: begin
                if (expire_c) begin
                    cnt_d   = CNT_FULL;
                    shift_d = {rxd_s, shift_q[UART_DATA_W-1:1]};
                    idx_d   = idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (expire_c) begin
                    cnt_d     = CNT_FULL;
                    par_bad_d = rxd_s ^ (^shift_q);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (expire_c) begin
                    cnt_d = CNT_FULL;
                    if (!rxd_s) ferr_c = rx_enable;
`ifdef UART_RX_PARITY_EN
                    else if (par_bad_q) perr_c = rx_enable;
`endif
                    else deliver_c = rx_enable;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: ;
        endcase

        // One-entry buffer: accept when empty or draining this cycle
        valid_d = valid_q;
        data_d  = data_q;
        ovr_d   = 1'b0;
        if (valid_q && rx_if.rx_ready) valid_d = 1'b0;
        if (deliver_c) begin
            if (!valid_q || rx_if.rx_ready) begin
                valid_d = 1'b1;
                data_d  = shift_q;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_c;
            ovr_q   <= ovr_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            par_bad_q <= par_bad_d;
            perr_q    <= perr_c;
        end
    end
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_if.rx_valid    = valid_q;
    assign rx_if.rx_data_out = data_q;
    assign frame_err         = ferr_q;
    assign overrun           = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected events, a negedge monitor pops and compares.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int unsigned CPB = 16;
    localparam int EV_BYTE = 0;
    localparam int EV_FERR = 1;
    localparam int EV_OVR  = 2;
    localparam int EV_PERR = 3;

    typedef struct {
        int       kind;
        bit [7:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic uart_rxd = 1'b1;
    logic rx_enable = 1'b1;
    logic frame_err, overrun, parity_err;

    uart_rx_if rx_if();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_rxd  (uart_rxd),
        .rx_enable (rx_enable),
        .rx_if     (rx_if),
        .frame_err (frame_err),
        .overrun   (overrun),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    ev_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;

    task automatic check_ev(input int kind, input bit [7:0] data);
        ev_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: got kind=%0d data=%02h, required none", kind, data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || (kind == EV_BYTE && e.data != data)) begin
                n_err++;
                $display("FAIL event_order: got kind=%0d data=%02h, required kind=%0d data=%02h",
                         kind, data, e.kind, e.data);
            end
        end
    endtask

    task automatic check_val(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push(input int kind, input bit [7:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        uart_rxd = b;
        tick(CPB);
    endtask

    // par_ok=0 inverts the even-parity bit when parity is built in
    task automatic send_frame(input bit [7:0] d, input logic stop, input bit par_ok);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ ~par_ok);
`else
        if (!par_ok) $display("note: parity not built, par_ok ignored");
`endif
        drive_bit(stop);
        uart_rxd = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 40 * CPB) begin
            tick(1);
            guard++;
        end
        tick(2 * CPB);
        check_val(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Monitor: transfer and error pulses, sampled away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (rx_if.rx_valid && rx_if.rx_ready) check_ev(EV_BYTE, rx_if.rx_data_out);
                if (frame_err)  check_ev(EV_FERR, 8'h00);
                if (overrun)    check_ev(EV_OVR, 8'h00);
                if (parity_err) check_ev(EV_PERR, 8'h00);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rx_if.rx_ready = 1'b1;
        tick(4);
        check_val("reset_valid", int'(rx_if.rx_valid), 0);
        check_val("reset_data", int'(rx_if.rx_data_out), 0);
        check_val("reset_ferr", int'(frame_err), 0);
        check_val("reset_ovr", int'(overrun), 0);
        check_val("reset_perr", int'(parity_err), 0);
        rst_n = 1'b1;
        tick(2 * CPB);

        // Single frame, consumer always ready
        push(EV_BYTE, 8'hA5);
        send_frame(8'hA5, 1'b1, 1'b1);
        wait_drain("a5_frame");

        // Back-to-back frames with consumer stalled
        rx_if.rx_ready = 1'b0;
        push(EV_OVR, 8'h00);
        push(EV_BYTE, 8'h21);
        send_frame(8'h21, 1'b1, 1'b1);
        send_frame(8'h5A, 1'b1, 1'b1);
        tick(2 * CPB);
        check_val("ovr_popped", exp_q.size(), 1);
        check_val("held_valid", int'(rx_if.rx_valid), 1);
        check_val("held_data", int'(rx_if.rx_data_out), 'h21);
        rx_if.rx_ready = 1'b1;
        wait_drain("overrun_drain");
        check_val("valid_cleared", int'(rx_if.rx_valid), 0);

        // Framing error with a break, then recovery
        push(EV_FERR, 8'h00);
        send_frame(8'h3C, 1'b0, 1'b1);
        uart_rxd = 1'b0;
        tick(3 * CPB);
        uart_rxd = 1'b1;
        tick(2 * CPB);
        push(EV_BYTE, 8'h11);
        send_frame(8'h11, 1'b1, 1'b1);
        wait_drain("ferr_recover");

        // Short glitch on an idle line
        uart_rxd = 1'b0;
        tick(3);
        uart_rxd = 1'b1;
        tick(2 * CPB);
        check_val("glitch_quiet", exp_q.size() + int'(rx_if.rx_valid), 0);
        push(EV_BYTE, 8'h7E);
        send_frame(8'h7E, 1'b1, 1'b1);
        wait_drain("glitch_then_7e");

        // Enable dropped mid-DATA: partial frame must vanish silently
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        uart_rxd = 1'b1;
        tick(CPB / 2);
        rx_enable = 1'b0;
        tick(1);
        rx_enable = 1'b1;
        tick(12 * CPB);
        check_val("abort_quiet", int'(rx_if.rx_valid), 0);
        push(EV_BYTE, 8'h42);
        send_frame(8'h42, 1'b1, 1'b1);
        wait_drain("abort_then_42");

`ifdef UART_RX_PARITY_EN
        push(EV_PERR, 8'h00);
        send_frame(8'h03, 1'b1, 1'b0);
        wait_drain("parity_bad");
        push(EV_BYTE, 8'h03);
        send_frame(8'h03, 1'b1, 1'b1);
        wait_drain("parity_good");
`else
        push(EV_BYTE, 8'h03);
        send_frame(8'h03, 1'b1, 1'b1);
        wait_drain("plain_03");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
